tdsp_mult_seq: RTL and testbench

Parametrised, multi-cycle signed multiplier / multiply-accumulator for the tiny DSP datapath. It generalises the single-cycle combinational multiplier as follows:
- operand width is a parameter;
- operation is a start/done handshake through a radix-2 shift-add sequence;
- an internal product/accumulator register supports TMS320-style MPY and MAC;
- MAC results saturate under overflow mode (ovm).

It sits between the operand registers and the accumulator/P-register path of the execution unit.

---
 rtl/tdsp_mult_pkg.sv | 32 +++
 rtl/tdsp_sat_add.sv | 32 +++
 rtl/tdsp_mult_seq.sv | 149 ++++++++++++++
 tb/tb_tdsp_mult_seq.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/tdsp_mult_pkg.sv
// Shared definitions for the sequential signed multiplier / MAC:
// FSM state encodings, default operand width and saturation constants.
package tdsp_mult_pkg;

  localparam int DEFAULT_W = 16;

  // Widest result the helper functions can describe (operands up to 64 bits)
  localparam int MAX_RW = 128;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_FIX  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  localparam logic [MAX_RW-1:0] ONE_MAX = {{(MAX_RW-1){1'b0}}, 1'b1};

  // Most-negative n-bit two's complement value: 1 followed by n-1 zeros
  function automatic logic [MAX_RW-1:0] most_neg(input int n);
    return ONE_MAX << (n - 1);
  endfunction

  // Positive saturation value for an n-bit result: 0 followed by n-1 ones
  function automatic logic [MAX_RW-1:0] psat(input int n);
    return most_neg(n) - ONE_MAX;
  endfunction

  // Negative saturation value for an n-bit result
  function automatic logic [MAX_RW-1:0] nsat(input int n);
    return most_neg(n);
  endfunction

endpackage

// File: rtl/tdsp_sat_add.sv
// Signed accumulate adder with overflow detection; when ovm is set an
// overflowing sum is clamped to the saturation value on the side of 'a'.
module tdsp_sat_add
  import tdsp_mult_pkg::*;
#(
  parameter int RW = 32
) (
  input  logic [RW-1:0] a,
  input  logic [RW-1:0] b,
  input  logic          ovm,
  output logic [RW-1:0] sum,
  output logic          ovf
);

  localparam logic [MAX_RW-1:0] PSAT_FULL = psat(RW);
  localparam logic [MAX_RW-1:0] NSAT_FULL = nsat(RW);
  localparam logic [RW-1:0]     PSAT      = PSAT_FULL[RW-1:0];
  localparam logic [RW-1:0]     NSAT      = NSAT_FULL[RW-1:0];

  logic [RW-1:0] raw;

  // Wrapping add, overflow when like-signed operands yield an opposite-signed sum
  always_comb begin
    raw = a + b;
    ovf = (a[RW-1] == b[RW-1]) && (raw[RW-1] != a[RW-1]);
    sum = raw;
    if (ovf && ovm) begin
      sum = a[RW-1] ? NSAT : PSAT;
    end
  end

endmodule

// File: rtl/tdsp_mult_seq.sv
// Multi-cycle signed multiplier / multiply-accumulator. Operands are turned
// into magnitudes, multiplied by a radix-2 shift-add loop over W cycles, then
// the sign is reapplied and the product either replaces or is added to the
// internal accumulator.
module tdsp_mult_seq
  import tdsp_mult_pkg::*;
#(
  parameter  int W  = DEFAULT_W,
  localparam int CW = $clog2(W + 1)
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  input  logic           ovm,
  input  logic           mac,
  input  logic           clr_acc,
  input  logic [W-1:0]   op_a,
  input  logic [W-1:0]   op_b,
  output logic           busy,
  output logic           done,
  output logic [2*W-1:0] result,
  output logic           ovf
);

  localparam int RW = 2 * W;

  localparam logic [MAX_RW-1:0] MOST_NEG_FULL = most_neg(W);
  localparam logic [W-1:0]      MOST_NEG      = MOST_NEG_FULL[W-1:0];
  localparam logic [W-1:0]      MAX_POS       = ~MOST_NEG;
  localparam logic [W-1:0]      ONE_W         = {{(W-1){1'b0}}, 1'b1};
  localparam logic [RW-1:0]     ONE_R         = {{(RW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0]     ONE_C         = CW'(1);
  localparam logic [CW-1:0]     LAST_COUNT    = CW'(W - 1);

  logic [1:0]    state;
  logic [CW-1:0] count;
  logic [W-1:0]  mag_a;
  logic [W-1:0]  mag_b;
  logic          sign_a;
  logic          sign_b;
  logic          ovm_q;
  logic          mac_q;
  logic [RW-1:0] prod;
  logic [RW-1:0] acc;

  logic [RW-1:0] addend;
  logic [W-1:0]  b_shifted;
  logic [RW-1:0] p_signed;
  logic [RW-1:0] mac_sum;
  logic          mac_ovf;

  // Magnitude of an operand; with ovm the most-negative value is clamped so
  // its magnitude stays representable as a positive W-bit number
  function automatic logic [W-1:0] operand_mag(input logic [W-1:0] op,
                                               input logic ovm_sel);
    if (ovm_sel && (op == MOST_NEG)) begin
      return MAX_POS;
    end else if (op[W-1]) begin
      return ~op + ONE_W;
    end else begin
      return op;
    end
  endfunction

  // Shifted multiplicand, current multiplier bit and signed product
  always_comb begin
    addend    = {{W{1'b0}}, mag_a} << count;
    b_shifted = mag_b >> count;
    p_signed  = (sign_a ^ sign_b) ? (~prod + ONE_R) : prod;
  end

  tdsp_sat_add #(
    .RW (RW)
  ) u_sat_add (
    .a   (acc),
    .b   (p_signed),
    .ovm (ovm_q),
    .sum (mac_sum),
    .ovf (mac_ovf)
  );

  // Control FSM with the shift-add datapath and result/accumulator registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= ST_IDLE;
      count  <= '0;
      mag_a  <= '0;
      mag_b  <= '0;
      sign_a <= 1'b0;
      sign_b <= 1'b0;
      ovm_q  <= 1'b0;
      mac_q  <= 1'b0;
      prod   <= '0;
      acc    <= '0;
      result <= '0;
      ovf    <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (clr_acc) begin
            acc <= '0;
          end
          if (start) begin
            ovm_q  <= ovm;
            mac_q  <= mac;
            sign_a <= op_a[W-1];
            sign_b <= op_b[W-1];
            mag_a  <= operand_mag(op_a, ovm);
            mag_b  <= operand_mag(op_b, ovm);
            prod   <= '0;
            count  <= '0;
            busy   <= 1'b1;
            state  <= ST_CALC;
          end
        end
        ST_CALC: begin
          if (b_shifted[0]) begin
            prod <= prod + addend;
          end
          count <= count + ONE_C;
          if (count == LAST_COUNT) begin
            state <= ST_FIX;
          end
        end
        ST_FIX: begin
          if (mac_q) begin
            result <= mac_sum;
            acc    <= mac_sum;
            ovf    <= mac_ovf;
          end else begin
            result <= p_signed;
            acc    <= p_signed;
            ovf    <= 1'b0;
          end
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= ST_DONE;
        end
        default: begin
          done  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tdsp_mult_seq.sv
// Directed self-checking bench for tdsp_mult_seq with W=16: MPY/MAC results,
// ovm clamping and saturation, latency, and start/reset/clr_acc corners.
module tb_tdsp_mult_seq;

  localparam int W = 16;

  logic          clk;
  logic          reset;
  logic          start;
  logic          ovm;
  logic          mac;
  logic          clr_acc;
  logic [W-1:0]  op_a;
  logic [W-1:0]  op_b;
  logic          busy;
  logic          done;
  logic [2*W-1:0] result;
  logic          ovf;

  int checks = 0;
  int passes = 0;
  int fails  = 0;

  tdsp_mult_seq #(
    .W (W)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .ovm     (ovm),
    .mac     (mac),
    .clr_acc (clr_acc),
    .op_a    (op_a),
    .op_b    (op_b),
    .busy    (busy),
    .done    (done),
    .result  (result),
    .ovf     (ovf)
  );

  // Free-running 100 MHz clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [63:0] obs,
                             input logic [63:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  // Present operands with start for exactly one edge, then scramble operands
  task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b,
                               input logic m, input logic o, input logic c);
    op_a    = a;
    op_b    = b;
    mac     = m;
    ovm     = o;
    clr_acc = c;
    start   = 1'b1;
    stepCycle();
    start   = 1'b0;
    clr_acc = 1'b0;
    op_a    = W'($urandom);
    op_b    = W'($urandom);
  endtask

  task automatic waitDone(output int edges, output int busyCnt);
    edges   = 0;
    busyCnt = 0;
    while (!done && edges < 40) begin
      if (busy) busyCnt++;
      stepCycle();
      edges++;
    end
    checkOutput("done_seen", {63'd0, done}, 64'd1);
  endtask

  task automatic runOp(input string tag, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic m, input logic o,
                       input logic c, input logic [2*W-1:0] expRes,
                       input logic expOvf);
    int edges;
    int busyCnt;
    applyStimulus(a, b, m, o, c);
    waitDone(edges, busyCnt);
    checkOutput({tag, "_result"}, {32'd0, result}, {32'd0, expRes});
    checkOutput({tag, "_ovf"}, {63'd0, ovf}, {63'd0, expOvf});
    stepCycle();
    checkOutput({tag, "_done_pulse"}, {63'd0, done}, 64'd0);
  endtask

  initial begin
    int edges;
    int busyCnt;
    int doneCnt;
    int busyHigh;

    reset   = 1'b1;
    start   = 1'b0;
    ovm     = 1'b0;
    mac     = 1'b0;
    clr_acc = 1'b0;
    op_a    = '0;
    op_b    = '0;
    stepCycle();
    stepCycle();
    reset = 1'b0;
    checkOutput("reset_busy", {63'd0, busy}, 64'd0);
    checkOutput("reset_done", {63'd0, done}, 64'd0);
    checkOutput("reset_result", {32'd0, result}, 64'd0);
    checkOutput("reset_ovf", {63'd0, ovf}, 64'd0);

    $display("[TB] MPY 3 * -5 with latency and busy length");
    applyStimulus(16'd3, 16'hFFFB, 1'b0, 1'b0, 1'b0);
    checkOutput("t1_busy_first", {63'd0, busy}, 64'd1);
    waitDone(edges, busyCnt);
    checkOutput("t1_latency", 64'(edges + 1), 64'd18);
    checkOutput("t1_busy_cycles", 64'(busyCnt), 64'd17);
    checkOutput("t1_busy_at_done", {63'd0, busy}, 64'd0);
    checkOutput("t1_result", {32'd0, result}, 64'hFFFF_FFF1);
    checkOutput("t1_ovf", {63'd0, ovf}, 64'd0);
    stepCycle();
    checkOutput("t1_done_pulse", {63'd0, done}, 64'd0);

    $display("[TB] most-negative operands");
    runOp("t2_mn_ovm0", 16'h8000, 16'h8000, 1'b0, 1'b0, 1'b0, 32'h4000_0000, 1'b0);
    runOp("t2_mn_ovm1", 16'h8000, 16'h8000, 1'b0, 1'b1, 1'b0, 32'h3FFF_0001, 1'b0);

    $display("[TB] MAC chain, wrapping");
    runOp("t3_mac1", 16'h7FFF, 16'h7FFF, 1'b1, 1'b0, 1'b1, 32'h3FFF_0001, 1'b0);
    runOp("t3_mac2", 16'h7FFF, 16'h7FFF, 1'b1, 1'b0, 1'b0, 32'h7FFE_0002, 1'b0);
    runOp("t3_mac3", 16'h7FFF, 16'h7FFF, 1'b1, 1'b0, 1'b0, 32'hBFFD_0003, 1'b1);

    $display("[TB] MAC chain, saturating");
    runOp("t4_mac1", 16'h7FFF, 16'h7FFF, 1'b1, 1'b1, 1'b1, 32'h3FFF_0001, 1'b0);
    runOp("t4_mac2", 16'h7FFF, 16'h7FFF, 1'b1, 1'b1, 1'b0, 32'h7FFE_0002, 1'b0);
    runOp("t4_mac3", 16'h7FFF, 16'h7FFF, 1'b1, 1'b1, 1'b0, 32'h7FFF_FFFF, 1'b1);
    runOp("t4_mpy0", 16'd0, 16'd0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0);

    $display("[TB] negative saturation");
    runOp("tn_mac1", 16'h8001, 16'h7FFF, 1'b1, 1'b1, 1'b1, 32'hC000_FFFF, 1'b0);
    runOp("tn_mac2", 16'h8001, 16'h7FFF, 1'b1, 1'b1, 1'b0, 32'h8001_FFFE, 1'b0);
    runOp("tn_mac3", 16'h8001, 16'h7FFF, 1'b1, 1'b1, 1'b0, 32'h8000_0000, 1'b1);

    $display("[TB] edge operands");
    runOp("t5_0xm1", 16'd0, 16'hFFFF, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
    runOp("t5_m1xm1", 16'hFFFF, 16'hFFFF, 1'b0, 1'b0, 1'b0, 32'd1, 1'b0);
    runOp("t5_m1xmax", 16'hFFFF, 16'h7FFF, 1'b0, 1'b0, 1'b0, 32'hFFFF_8001, 1'b0);

    $display("[TB] start pulses during CALC and DONE");
    applyStimulus(16'd7, 16'd9, 1'b0, 1'b0, 1'b0);
    stepCycle();
    stepCycle();
    op_a  = 16'd5;
    op_b  = 16'd5;
    start = 1'b1;
    stepCycle();
    start = 1'b0;
    waitDone(edges, busyCnt);
    checkOutput("t6_calc_start_result", {32'd0, result}, 64'd63);
    op_a  = 16'd5;
    op_b  = 16'd5;
    start = 1'b1;
    stepCycle();
    start = 1'b0;
    doneCnt  = 0;
    busyHigh = 0;
    for (int i = 0; i < 25; i++) begin
      if (done) doneCnt++;
      if (busy) busyHigh++;
      stepCycle();
    end
    checkOutput("t6_extra_done", 64'(doneCnt), 64'd0);
    checkOutput("t6_no_restart", 64'(busyHigh), 64'd0);
    checkOutput("t6_result_held", {32'd0, result}, 64'd63);

    $display("[TB] reset mid-CALC");
    applyStimulus(16'd3, 16'd3, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) stepCycle();
    reset = 1'b1;
    stepCycle();
    reset = 1'b0;
    checkOutput("t6_rst_busy", {63'd0, busy}, 64'd0);
    checkOutput("t6_rst_result", {32'd0, result}, 64'd0);
    doneCnt = 0;
    for (int i = 0; i < 25; i++) begin
      if (done) doneCnt++;
      stepCycle();
    end
    checkOutput("t6_rst_no_done", 64'(doneCnt), 64'd0);

    $display("[TB] clr_acc during CALC and alone in IDLE");
    runOp("t6_clr_base", 16'd2, 16'd3, 1'b1, 1'b0, 1'b1, 32'd6, 1'b0);
    applyStimulus(16'd2, 16'd5, 1'b1, 1'b0, 1'b0);
    clr_acc = 1'b1;
    for (int i = 0; i < 5; i++) stepCycle();
    clr_acc = 1'b0;
    waitDone(edges, busyCnt);
    checkOutput("t6_clr_calc_result", {32'd0, result}, 64'd16);
    stepCycle();
    clr_acc = 1'b1;
    stepCycle();
    clr_acc = 1'b0;
    runOp("t6_clr_idle", 16'd2, 16'd5, 1'b1, 1'b0, 1'b0, 32'd10, 1'b0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
